img_receive_uart: RTL and testbench
===================================

# img_receive_uart

- Receives a 150×150 8-bit grayscale image (22500 bytes) over a 9600-baud 8N1 UART line.
- Writes each received byte into the image BRAM at sequential addresses, starting at address 0.
- This is the ingress stage of the pipeline: it fills the BRAM that the enhancement core reads and the UART image transmitter later drains.
- Raises `done` once the full frame is stored.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10416: clock cycles per UART bit (100 MHz / 9600).
- `NUM_PIXELS`, 22500: bytes per frame.
- `ADDR_W`, 15: BRAM address width.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `RxD`, in, 1: asynchronous serial input; idle high.
- `ena_rx`, out, 1: BRAM port enable; constant 1.
- `wea_rx`, out, 1: BRAM write enable; one-cycle pulse per stored byte.
- `addr_rx`, out, ADDR_W: BRAM write address.
- `din_rx`, out, 8: BRAM write data.
- `done`, out, 1: full frame stored; sticky until reset.
- `frame_err`, out, 1: sticky framing-error flag. Tied to 0 unless `IMG_RX_FRAME_CHECK_EN` is defined.

## Operation
- `RxD` passes through a 2-flop synchronizer before any use. The synchronizer resets to 1.
- FSM states: IDLE, START, DATA, STOP, WRITE, DONE.
- **IDLE**
  - On synchronized `RxD` = 0: clear the baud counter and go to START.
- **START**
  - Count to `CLKS_PER_BIT/2 - 1` (5207).
  - At that count: if the line is still 0, clear the counter and bit index, then go to DATA.
  - Otherwise (glitch): return to IDLE with no write.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, sample the line into `shift_reg`, LSB first, at bit centres.
  - After the 8th sample, go to STOP.
- **STOP**
  - After `CLKS_PER_BIT` more cycles, sample the stop bit and go to WRITE.
- **WRITE** (one cycle)
  - Assert `wea_rx`, with `din_rx` = `shift_reg` and `addr_rx` = current address.
  - Next cycle: address increments by 1.
  - If that write was address `NUM_PIXELS-1`, go to DONE; otherwise go to IDLE.
- **DONE**
  - Terminal state: further `RxD` activity is ignored and `wea_rx` stays 0.
  - `addr_rx` holds `NUM_PIXELS-1`.
  - Only `reset` leaves DONE.
- **Arithmetic**
  - Baud counter is 14 bits and wraps to 0 on every terminal count.
  - Address never exceeds `NUM_PIXELS-1`; there is no wrap.
- **Reset** (from any state, including mid-byte)
  - Go to IDLE; `addr_rx` = 0, `din_rx` = 0, `wea_rx` = 0, `done` = 0, `frame_err` = 0.
  - A partial byte is discarded.

## Timing
- Start detection takes 2 cycles after the line falls (synchronizer latency).
- Start-bit verification happens 5208 cycles after detection.
- Data bit k (0..7) is sampled at 5208 + (k+1)·10416 cycles after detection.
- The stop bit is sampled at 5208 + 9·10416 cycles after detection.
- `wea_rx` pulses on the cycle after the stop sample. `addr_rx` and `din_rx` are stable during that cycle.
- IDLE is re-entered mid-stop-bit, so back-to-back bytes with no idle gap are accepted.
- `done` rises on the cycle after the final write and is high within 1 cycle of the last `wea_rx` pulse.

## Configuration
- `IMG_RX_FRAME_CHECK_EN` defined:
  - A stop bit sampled as 0 suppresses the WRITE for that byte. The address is not incremented.
  - `frame_err` is set and stays set until reset.
  - FSM goes to IDLE only after the line returns high; it waits in STOP until then.
- `IMG_RX_FRAME_CHECK_EN` undefined:
  - The stop-bit value is ignored and every byte is written.
  - `frame_err` is constant 0.

## Structure
- Shared package `img_uart_pkg`: `CLKS_PER_BIT`, `NUM_PIXELS`, `ADDR_W`, and the RX state enum.
  - Shared with the transmitter so baud rate and frame size cannot diverge.
- One sub-module, `uart_rx_byte`:
  - Contains the synchronizer, START/DATA/STOP deframer and baud counter.
  - Emits a one-cycle `byte_valid`, plus `byte_data[7:0]` and `stop_ok`.
- The top handles WRITE/DONE, address counting and `frame_err`.

## Test plan
- **Reset values:** assert `reset` → `wea_rx`=0, `addr_rx`=0, `din_rx`=0, `done`=0, `frame_err`=0, `ena_rx`=1.
- **Single byte:** drive 8N1 byte 0xA5 at 10416 clk/bit → exactly one `wea_rx` pulse, `din_rx`=0xA5, `addr_rx`=0; `addr_rx`=1 on the next cycle.
- **Glitch rejection:** 3000-cycle low pulse on an idle line → no write, FSM back in IDLE, `addr_rx` unchanged.
- **Full frame:** 22500 back-to-back bytes, value = address mod 256 → BRAM contents match; `done`=1 after the last write. A 22501st byte → no write, `addr_rx`=22499.
- **Reset mid-byte:** pulse `reset` during bit 4 of 0x3C, then send 0x77 → single write of 0x77 at address 0.
- **Bad stop bit:** send 0x55 with stop bit = 0.
  - With `IMG_RX_FRAME_CHECK_EN`: no write, `frame_err`=1, next good byte lands at address 0.
  - Without it: 0x55 is written at address 0 and `frame_err`=0.

Source files
------------

// File: rtl/img_uart_pkg.sv
// Shared UART image-link constants and RX state encoding, common to the
// receiver and transmitter so baud rate and frame size stay in lockstep.
package img_uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 10416;
    localparam int unsigned NUM_PIXELS   = 22500;
    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned BAUD_W       = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WRITE,
        DONE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 deframer: RxD synchronizer, start/data/stop sequencing and baud counter.
// IMG_RX_FRAME_CHECK_EN: hold in STOP after a bad stop bit until the line idles.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = img_uart_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_ok
);
    import img_uart_pkg::*;

    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_M1  = BAUD_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync;
    logic              rx_s;
    rx_state_t         state;
    logic [BAUD_W-1:0] cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
`ifdef IMG_RX_FRAME_CHECK_EN
    logic              stop_wait;
`endif

    assign rx_s      = sync[1];
    assign byte_data = shift_reg;
    assign stop_ok   = rx_s;

    // Strobe coincides with the stop-bit sample so the top can write next cycle.
`ifdef IMG_RX_FRAME_CHECK_EN
    assign byte_valid = (state == STOP) && (cnt == BIT_M1) && !stop_wait;
`else
    assign byte_valid = (state == STOP) && (cnt == BIT_M1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RxD};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef IMG_RX_FRAME_CHECK_EN
            stop_wait <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
`ifdef IMG_RX_FRAME_CHECK_EN
                    if (stop_wait) begin
                        if (rx_s) begin
                            stop_wait <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + BAUD_W'(1);
                    end
`else
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + BAUD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/img_receive_uart.sv
// UART image ingress: stores each received byte at sequential BRAM addresses.
// IMG_RX_FRAME_CHECK_EN: drop bytes with a bad stop bit and flag frame_err.
module img_receive_uart #(
    parameter int unsigned CLKS_PER_BIT = img_uart_pkg::CLKS_PER_BIT,
    parameter int unsigned NUM_PIXELS   = img_uart_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W       = img_uart_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RxD,
    output logic              ena_rx,
    output logic              wea_rx,
    output logic [ADDR_W-1:0] addr_rx,
    output logic [7:0]        din_rx,
    output logic              done,
    output logic              frame_err
);
    import img_uart_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
`ifdef IMG_RX_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    rx_state_t  state;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       stop_ok;
    logic       accept;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_ok   (stop_ok)
    );

    assign ena_rx = 1'b1;
    assign accept = byte_valid && (stop_ok || !FRAME_CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wea_rx  <= 1'b0;
            addr_rx <= '0;
            din_rx  <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wea_rx <= 1'b1;
                        din_rx <= byte_data;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    wea_rx <= 1'b0;
                    // Final address is held rather than advanced, so it never wraps.
                    if (addr_rx == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr_rx <= addr_rx + ADDR_W'(1);
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    wea_rx <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMG_RX_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (state == IDLE && byte_valid && !stop_ok) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_img_receive_uart.sv
// Self-checking bench for img_receive_uart with a shortened bit time and frame.
module tb_img_receive_uart;

    localparam int unsigned CPB = 8;
    localparam int unsigned NP  = 300;
    localparam int unsigned AW  = 15;
`ifdef IMG_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          RxD = 1'b1;
    logic          ena_rx, wea_rx, done, frame_err;
    logic [AW-1:0] addr_rx;
    logic [7:0]    din_rx;

    img_receive_uart #(
        .CLKS_PER_BIT(CPB),
        .NUM_PIXELS  (NP),
        .ADDR_W      (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RxD      (RxD),
        .ena_rx   (ena_rx),
        .wea_rx   (wea_rx),
        .addr_rx  (addr_rx),
        .din_rx   (din_rx),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_write;
        logic       exp_ferr;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[6];
    logic [7:0]    mem[NP];
    logic [AW-1:0] exp_addr;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle(input int unsigned n);
        RxD = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        RxD = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (CPB) @(posedge clk);
        end
        RxD = stop;
        repeat (CPB) @(posedge clk);
        RxD = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_addr = '0;
    endtask

    // Pops the scoreboard on every write pulse and checks the address step after it.
    task automatic monitor();
        logic          pend = 1'b0;
        logic          last = 1'b0;
        logic [AW-1:0] nxt  = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("addr_after_write", 32'(addr_rx), 32'(nxt));
                    if (last) chk("done_after_last", 32'(done), 32'd1);
                    pend = 1'b0;
                end
                if (wea_rx) begin
                    if (addr_rx < AW'(NP)) mem[addr_rx] = din_rx;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write actual addr=%0d din=%02h required no write",
                                 addr_rx, din_rx);
                    end else begin
                        e = sb.pop_front();
                        if (addr_rx !== e.addr || din_rx !== e.data) begin
                            errors++;
                            $display("FAIL write actual addr=%0d din=%02h required addr=%0d din=%02h",
                                     addr_rx, din_rx, e.addr, e.data);
                        end
                        pend = 1'b1;
                        last = (e.addr == AW'(NP - 1));
                        nxt  = last ? e.addr : e.addr + AW'(1);
                    end
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b0, !FC, FC};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, FC};
        vecs[2] = '{8'h00, 1'b1, 1'b1, FC};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, FC};
        vecs[4] = '{8'h81, 1'b1, 1'b1, FC};
        vecs[5] = '{8'h55, 1'b1, 1'b1, FC};
        exp_addr = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wea", 32'(wea_rx), 32'd0);
        chk("rst_addr", 32'(addr_rx), 32'd0);
        chk("rst_din", 32'(din_rx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ena", 32'(ena_rx), 32'd1);
        reset = 1'b0;
        idle(4);

        // Single byte
        sb.push_back('{addr: AW'(0), data: 8'hA5});
        send_byte(8'hA5, 1'b1);
        idle(CPB);
        @(negedge clk);
        chk("single_addr", 32'(addr_rx), 32'd1);
        chk("single_din", 32'(din_rx), 32'hA5);

        // Glitch shorter than half a bit
        RxD = 1'b0;
        repeat (2) @(posedge clk);
        idle(3 * CPB);
        @(negedge clk);
        chk("glitch_addr", 32'(addr_rx), 32'd1);

        // Table of bytes, starting from a fresh frame with a bad stop bit
        do_reset();
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].exp_write) begin
                sb.push_back('{addr: exp_addr, data: vecs[v].data});
                exp_addr = exp_addr + AW'(1);
            end
            send_byte(vecs[v].data, vecs[v].stop_bit);
            idle(2 * CPB);
            @(negedge clk);
            chk("vec_addr", 32'(addr_rx), 32'(exp_addr));
            chk("vec_ferr", 32'(frame_err), 32'(vecs[v].exp_ferr));
        end

        // Reset in the middle of bit 4 of 0x3C, then a clean 0x77
        begin
            logic [7:0] b = 8'h3C;
            RxD = 1'b0;
            repeat (CPB) @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                RxD = b[i];
                repeat (CPB) @(posedge clk);
            end
            RxD = b[4];
            repeat (CPB / 2) @(posedge clk);
        end
        do_reset();
        @(negedge clk);
        chk("midrst_addr", 32'(addr_rx), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        idle(2 * CPB);
        sb.push_back('{addr: AW'(0), data: 8'h77});
        send_byte(8'h77, 1'b1);
        idle(2 * CPB);
        @(negedge clk);
        chk("midrst_after_addr", 32'(addr_rx), 32'd1);
        chk("midrst_din", 32'(din_rx), 32'h77);

        // Full back-to-back frame, then one surplus byte
        do_reset();
        for (int i = 0; i < NP; i++) begin
            sb.push_back('{addr: AW'(i), data: 8'(i % 256)});
            send_byte(8'(i % 256), 1'b1);
        end
        idle(2 * CPB);
        @(negedge clk);
        chk("frame_done", 32'(done), 32'd1);
        chk("frame_addr", 32'(addr_rx), 32'(NP - 1));
        send_byte(8'hEE, 1'b1);
        idle(2 * CPB);
        @(negedge clk);
        chk("extra_addr", 32'(addr_rx), 32'(NP - 1));
        chk("extra_done", 32'(done), 32'd1);
        chk("extra_wea", 32'(wea_rx), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < NP; i++) begin
            chk("bram", 32'(mem[i]), 32'(i % 256));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
